seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised successor to the single-digit hex 7-segment decoder. Drives NUM_DIGITS common-anode hex digits over one shared, time-multiplexed segment bus. Adds double-buffered, tear-free updates, anti-ghosting guard time, leading-zero blanking and per-digit blanking. Sits between the calculator datapath (value to display) and the board's 7-segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
SCAN_DIV, 50000, clock cycles per digit slot; must be at least 2.
GUARD_CYC, 16, cycles at the start of each slot with all digits off; must be less than SCAN_DIV.

Ports:
iCLK  in  1  system clock; the only clock.
iRST  in  1  reset, asynchronous, active-high.
iDATA  in  4*NUM_DIGITS  hex nibbles; digit k is bits [4k+3:4k]; digit 0 is rightmost.
iLOAD  in  1  one-cycle strobe that captures iDATA (and iDP when compiled in).
iLZB  in  1  leading-zero blanking enable; level, sampled every cycle.
iBLANK_MASK  in  NUM_DIGITS  bit k=1 forces digit k blank; level.
oSEG  out  7  segments, negative logic (0=lit); bit0 t, bit1 rt, bit2 rb, bit3 b, bit4 lb, bit5 lt, bit6 m.
oANODE  out  NUM_DIGITS  digit enables, active-low; at most one bit low.
oPENDING  out  1  high while captured data waits for the frame boundary.

Behaviour:
- Reset (async assert): oSEG=7'h7F, oANODE all 1, oPENDING=0. Prescaler=0, digit index=0, shadow and display registers=0.
- After reset release, scanning starts at digit 0.
- Prescaler counts 0..SCAN_DIV-1 and wraps; each wrap advances the digit index 0..NUM_DIGITS-1, wrapping to 0.
- Frame boundary: the cycle where prescaler=SCAN_DIV-1 and index=NUM_DIGITS-1.
- Glyphs (hex 0-F, negative logic): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Output register stage: oSEG/oANODE are registered, so they show the prescaler/index value of the previous cycle.
- Guard window (prescaler < GUARD_CYC): oANODE all 1, oSEG=7F.
- Active window (remainder of the slot): oANODE has bit[index]=0, all others 1; oSEG=glyph of display nibble[index], or 7F if that digit is blanked.
- Digit k is blanked if iBLANK_MASK[k]=1.
- Digit k is also blanked if iLZB=1, k>0, and every display nibble from k up to NUM_DIGITS-1 is 0. Digit 0 is never blanked by LZB.
- iLOAD on a non-boundary cycle: shadow<=iDATA, oPENDING<=1; the display register is unchanged.
- Frame boundary with oPENDING=1 and no iLOAD: display<=shadow, oPENDING<=0.
- iLOAD on a boundary cycle: display<=iDATA and shadow<=iDATA, oPENDING<=0; the new load wins.
- Repeated iLOAD before a boundary: the last value wins.
- iRST mid-frame: everything returns to reset values immediately; any pending data is discarded.
- Counter widths are sized from the parameters (clog2); no overflow is possible for legal parameters.

Optional Feature:
Macro SEG7_DP_EN.
- Defined: adds port iDP (in, NUM_DIGITS) and port oDP (out, 1, active-low decimal point).
- iDP is captured into shadow/display on exactly the same rules as iDATA.
- oDP=~dp[index] in the active window; oDP=1 in the guard window, when the digit is blanked, and in reset.
- Not defined: iDP and oDP do not exist, and there is no decimal-point logic.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYC=2.
1. Assert iRST mid-slot while digit 2 is lit -> same cycle oSEG=7F, oANODE=1111, oPENDING=0; after release, the first lit digit is digit 0 (oANODE=1110).
2. iLOAD with iDATA=16'h12AF, run one frame past the boundary -> digit0 oSEG=0001110 with oANODE=1110; digit1 0001000; digit2 0100100; digit3 1111001 with oANODE=0111; each digit lit for 6 cycles per 8-cycle slot, preceded by 2 guard cycles of 1111/7F.
3. iLOAD 16'h5555 during digit-1 slot, display holding 16'h1234 -> oPENDING=1, and digits 2-3 still show 2 and 1 until the boundary; then oPENDING=0 and all digits show 0010010.
4. iLOAD on the exact boundary cycle with 16'h00FF -> oPENDING stays 0; the next frame shows F,F,0,0 immediately.
5. iLZB=1, display=16'h0030 -> digits 3 and 2 oSEG=7F; digit1=0110000; digit0=1000000. Display=16'h0000 -> only digit0 lit, showing 1000000.
6. iBLANK_MASK=4'b0100, display=16'h8888 -> digit2 oSEG=7F; others 0000000. With SEG7_DP_EN and iDP=4'b0001 -> oDP=0 only in digit-0 active cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex 7-segment scanner with tear-free double-buffered loads
// Ports: iCLK/iRST (async active-high reset), iDATA nibbles (digit 0 rightmost), iLOAD capture strobe,
// iLZB leading-zero blanking, iBLANK_MASK per-digit blank, oSEG (active-low segments),
// oANODE (active-low digit enables), oPENDING (captured data waiting for the frame boundary).
// Optional SEG7_DP_EN adds iDP (per-digit decimal points) and oDP (active-low decimal point).
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD_CYC  = 16
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic                    iLOAD,
    input  logic                    iLZB,
    input  logic [NUM_DIGITS-1:0]   iBLANK_MASK,
`ifdef SEG7_DP_EN
    input  logic [NUM_DIGITS-1:0]   iDP,
    output logic                    oDP,
`endif
    output logic [6:0]              oSEG,
    output logic [NUM_DIGITS-1:0]   oANODE,
    output logic                    oPENDING
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_GUARD = PW'(GUARD_CYC);
    localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
    logic                    pend_q, pend_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    wrap, bnd, guard, off;
    logic [3:0]              nib;
    logic [NUM_DIGITS:0]     zero_up;
    logic [NUM_DIGITS-1:0]   blank;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dps_q, dps_d, dpd_q, dpd_d;
    logic                    dp_q, dp_d;
`endif

    always_comb begin
        wrap     = presc_q == P_LAST;
        bnd      = wrap && idx_q == I_LAST;
        presc_d  = wrap ? '0 : presc_q + 1'b1;
        idx_d    = !wrap ? idx_q : (idx_q == I_LAST ? '0 : idx_q + 1'b1);
        // A load landing on the boundary goes straight to the display and wins over any pending shadow
        shadow_d = iLOAD ? iDATA : shadow_q;
        disp_d   = (iLOAD && bnd) ? iDATA : (bnd && pend_q) ? shadow_q : disp_q;
        pend_d   = iLOAD ? !bnd : (bnd ? 1'b0 : pend_q);
        // zero_up[k]: every display nibble from k to the top digit is zero
        zero_up  = '1;
        blank    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_up[k] = zero_up[k+1] && disp_q[4*k +: 4] == 4'h0;
            blank[k]   = iBLANK_MASK[k] || (iLZB && k != 0 && zero_up[k]);
        end
        nib      = disp_q[{idx_q, 2'b00} +: 4];
        guard    = presc_q < P_GUARD;
        off      = guard || blank[idx_q];
        seg_d    = off ? 7'h7F : GLYPH[nib];
        // A blanked digit keeps its anode enabled; only its segments go dark
        anode_d  = guard ? '1 : ~(NUM_DIGITS'(1) << idx_q);
`ifdef SEG7_DP_EN
        dps_d    = iLOAD ? iDP : dps_q;
        dpd_d    = (iLOAD && bnd) ? iDP : (bnd && pend_q) ? dps_q : dpd_q;
        dp_d     = off ? 1'b1 : ~dpd_q[idx_q];
`endif
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            presc_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            seg_q    <= 7'h7F;
            anode_q  <= '1;
`ifdef SEG7_DP_EN
            dps_q    <= '0;
            dpd_q    <= '0;
            dp_q     <= 1'b1;
`endif
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            seg_q    <= seg_d;
            anode_q  <= anode_d;
`ifdef SEG7_DP_EN
            dps_q    <= dps_d;
            dpd_q    <= dpd_d;
            dp_q     <= dp_d;
`endif
        end
    end

    assign oSEG     = seg_q;
    assign oANODE   = anode_q;
    assign oPENDING = pend_q;
`ifdef SEG7_DP_EN
    assign oDP      = dp_q;
`endif
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 guard cycles)
module tb_seg7_scan_driver;
    localparam int N = 4;
    localparam int S = 8;
    localparam int G = 2;
    localparam int F = N * S;
    localparam logic [6:0] GLY [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef logic [3:0][6:0] segs_t;
    typedef struct {
        logic [15:0] data;
        logic        lzb;
        logic [3:0]  mask;
        logic [3:0]  dp;
        segs_t       exp;
    } vec_t;

    logic        iCLK = 1'b0, iRST = 1'b0, iLOAD = 1'b0, iLZB = 1'b0;
    logic [15:0] iDATA = '0;
    logic [3:0]  iBLANK_MASK = '0;
    logic [3:0]  iDP = '0;
    logic [6:0]  oSEG;
    logic [3:0]  oANODE;
    logic        oPENDING;
`ifdef SEG7_DP_EN
    logic        oDP;
`endif

    int errors = 0;
    int checks = 0;
    int cyc;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_dpd, m_dps;
    logic        m_pend;
    vec_t        tbl [5];

    always #5 iCLK = ~iCLK;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .GUARD_CYC(G)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iLOAD(iLOAD), .iLZB(iLZB),
        .iBLANK_MASK(iBLANK_MASK),
`ifdef SEG7_DP_EN
        .iDP(iDP), .oDP(oDP),
`endif
        .oSEG(oSEG), .oANODE(oANODE), .oPENDING(oPENDING)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Model: slot position is derived from the cycle count since reset release
    task automatic step();
        int p, k;
        logic [3:0] nib;
        logic blank, bnd;
        logic [6:0] es;
        logic [3:0] ea;
        logic ed;
        p     = cyc % S;
        k     = (cyc / S) % N;
        nib   = m_disp[4*k +: 4];
        blank = iBLANK_MASK[k] || (iLZB && k > 0 && (m_disp >> (4*k)) == 16'h0);
        es    = (p < G || blank) ? 7'h7F : GLY[nib];
        ea    = (p < G) ? 4'hF : ~(4'b0001 << k);
        ed    = (p < G || blank) ? 1'b1 : ~m_dpd[k];
        bnd   = (cyc % F) == F - 1;
        @(posedge iCLK);
        if (iLOAD) begin
            m_shadow = iDATA;
            m_dps    = iDP;
            if (bnd) begin
                m_disp = iDATA;
                m_dpd  = iDP;
            end
            m_pend = !bnd;
        end else if (bnd && m_pend) begin
            m_disp = m_shadow;
            m_dpd  = m_dps;
            m_pend = 1'b0;
        end
        cyc++;
        #1;
        chk("seg", oSEG, es);
        chk("anode", oANODE, ea);
        chk("pending", oPENDING, m_pend);
`ifdef SEG7_DP_EN
        chk("dp", oDP, ed);
`endif
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        #1;
        chk("rst_seg", oSEG, 7'h7F);
        chk("rst_anode", oANODE, 4'hF);
        chk("rst_pend", oPENDING, 1'b0);
        cyc = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0; m_dpd = '0; m_dps = '0;
        @(posedge iCLK);
        #1;
        chk("rst_hold_seg", oSEG, 7'h7F);
        chk("rst_hold_anode", oANODE, 4'hF);
        iRST = 1'b0;
    endtask

    task automatic load(input logic [15:0] d);
        iDATA = d;
        iLOAD = 1'b1;
        step();
        iLOAD = 1'b0;
    endtask

    task automatic settle();
        for (int i = 0; i < 2 * F && oPENDING; i++) step();
        chk("pend_clear", oPENDING, 1'b0);
        step();
    endtask

    task automatic check_frame(input segs_t exp, input logic [3:0] dp);
        int lit [4];
        lit = '{default: 0};
        for (int i = 0; i < F; i++) begin
            step();
            if (oANODE == 4'hF) chk("guard_seg", oSEG, 7'h7F);
            else for (int k = 0; k < N; k++) if (!oANODE[k]) begin
                lit[k]++;
                chk($sformatf("frame_seg_d%0d", k), oSEG, exp[k]);
`ifdef SEG7_DP_EN
                chk($sformatf("frame_dp_d%0d", k), oDP, exp[k] == 7'h7F ? 1'b1 : ~dp[k]);
`endif
            end
        end
        for (int k = 0; k < N; k++) chk($sformatf("lit_cnt_d%0d", k), lit[k], S - G);
    endtask

    initial begin
        logic found;
        tbl[0] = '{16'h12AF, 1'b0, 4'b0000, 4'b0000, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
        tbl[1] = '{16'h0030, 1'b1, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'b0110000, 7'b1000000}};
        tbl[2] = '{16'h0000, 1'b1, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}};
        tbl[3] = '{16'h8888, 1'b0, 4'b0100, 4'b0001, {7'b0000000, 7'h7F, 7'b0000000, 7'b0000000}};
        tbl[4] = '{16'hE0D7, 1'b1, 4'b0000, 4'b1010, {7'b0000110, 7'b1000000, 7'b0100001, 7'b1111000}};
        #1;
        do_reset();

        for (int v = 0; v < 5; v++) begin
            iLZB = tbl[v].lzb;
            iBLANK_MASK = tbl[v].mask;
            iDP = tbl[v].dp;
            load(tbl[v].data);
            settle();
            check_frame(tbl[v].exp, tbl[v].dp);
        end
        iLZB = 1'b0; iBLANK_MASK = '0; iDP = '0;

        // Load during the digit-1 slot: old digits stay until the boundary, then all show 5
        load(16'h1234);
        settle();
        for (int i = 0; i < F && !((cyc / S) % N == 1 && cyc % S == 3); i++) step();
        load(16'h5555);
        chk("t3_pend_set", oPENDING, 1'b1);
        for (int i = 0; i < F && oPENDING; i++) begin
            step();
            if (oANODE == 4'b1011) chk("t3_old_d2", oSEG, 7'b0100100);
            if (oANODE == 4'b0111) chk("t3_old_d3", oSEG, 7'b1111001);
        end
        chk("t3_pend_clear", oPENDING, 1'b0);
        step();
        check_frame({4{7'b0010010}}, 4'b0000);

        // Load on the boundary cycle: never pending, shows in the next frame
        for (int i = 0; i < F && (cyc % F) != F - 1; i++) step();
        load(16'h00FF);
        chk("t4_no_pend", oPENDING, 1'b0);
        step();
        check_frame({7'b1000000, 7'b1000000, 7'b0001110, 7'b0001110}, 4'b0000);

        // Reset while digit 2 is lit with data pending
        load(16'hBEEF);
        found = 1'b0;
        for (int i = 0; i < 2 * F; i++) begin
            step();
            if (oANODE == 4'b1011) begin found = 1'b1; break; end
        end
        chk("t1_find_d2", found, 1'b1);
        step();
        do_reset();
        found = 1'b0;
        for (int i = 0; i < S; i++) begin
            step();
            if (oANODE != 4'hF) begin found = 1'b1; break; end
        end
        chk("t1_lit_found", found, 1'b1);
        chk("t1_first_d0", oANODE, 4'b1110);

        for (int i = 0; i < 400; i++) begin
            iLOAD = ($urandom % 8) == 0;
            iDATA = 16'($urandom);
            iDP = 4'($urandom);
            if ($urandom % 16 == 0) iLZB = 1'($urandom);
            iBLANK_MASK = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
            if ($urandom % 3 == 0) iDATA = iDATA & 16'h00FF;
            step();
        end
        iLOAD = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
